// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W     = 64;
    localparam int DEF_DATA_W     = 64;
    localparam int DEF_STARVE_MAX = 4;
    // Wide enough for any STARVE_MAX in 1..15.
    localparam int STARVE_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CORE_RSP = 2'd1,
        LDR_RSP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive denied loader cycles; at_max_o forces
// the loader to win the next conflict with the core.
module arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam logic [STARVE_CNT_W-1:0] MAX_V = STARVE_CNT_W'(MAX);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over increment; increment saturates at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-ported data memory between the core MEM stage and
// the loader/debug port. Core wins conflicts until the loader has been
// denied STARVE_MAX cycles in a row. Reads take one response cycle.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined;
// otherwise the stat outputs are tied to zero.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       stat_core_stall_cnt,
    output logic [31:0]       stat_ldr_gnt_cnt
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] ldr_rdata_q;
    logic              can_core;
    logic              core_win;
    logic              ldr_win;
    logic              at_max;

    arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc_i    (ldr_req & ~ldr_win),
        .clr_i    (ldr_win | ~ldr_req),
        .at_max_o (at_max)
    );

    // Winner selection; the core is never re-granted in its response cycle.
    always_comb begin
        can_core = core_req && (state_q != CORE_RSP);
        core_win = ~reset & can_core & (~ldr_req | ~at_max);
        ldr_win  = ~reset & ldr_req & (~can_core | at_max);
    end

    // Memory port mux; address/data hold their last value when idle.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (core_win) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (ldr_win) begin
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end
        mem_we = (core_win & core_we) | (ldr_win & ldr_we);
        mem_re = (core_win & ~core_we) | (ldr_win & ~ldr_we);
    end

    // A granted read moves to its requester's response state.
    always_comb begin
        state_d = IDLE;
        if (ldr_win && !ldr_we) begin
            state_d = LDR_RSP;
        end else if (core_win && !core_we) begin
            state_d = CORE_RSP;
        end
    end

    // FSM, held memory address/data and read-data capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rdata_q <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (core_win || ldr_win) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            if (core_win && !core_we) begin
                core_rdata_q <= mem_rdata;
            end
            if (ldr_win && !ldr_we) begin
                ldr_rdata_q <= mem_rdata;
            end
        end
    end

    assign core_stall  = ~reset & core_req & ~((core_win & core_we) | (state_q == CORE_RSP));
    assign core_rvalid = (state_q == CORE_RSP);
    assign core_rdata  = core_rdata_q;
    assign ldr_gnt     = ldr_win;
    assign ldr_rvalid  = (state_q == LDR_RSP);
    assign ldr_rdata   = ldr_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] gnt_cnt_q;

    // Saturating stall-cycle and loader-grant statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            gnt_cnt_q   <= '0;
        end else begin
            if (core_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ldr_gnt && (gnt_cnt_q != 32'hFFFF_FFFF)) begin
                gnt_cnt_q <= gnt_cnt_q + 32'd1;
            end
        end
    end

    assign stat_core_stall_cnt = stall_cnt_q;
    assign stat_ldr_gnt_cnt    = gnt_cnt_q;
`else
    assign stat_core_stall_cnt = 32'd0;
    assign stat_ldr_gnt_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter with a small behavioural memory.
module tb_dmem_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_stall, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          ldr_req, ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_gnt, ldr_rvalid;
    logic [DW-1:0] ldr_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we, mem_re;
    logic [DW-1:0] mem_rdata;
    logic [31:0]   stat_core_stall_cnt, stat_ldr_gnt_cnt;

    logic [DW-1:0] tb_mem [32];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr[7:3]];

    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr[7:3]] <= mem_wdata;
    end

    dmem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SM)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .core_req            (core_req),
        .core_we             (core_we),
        .core_addr           (core_addr),
        .core_wdata          (core_wdata),
        .core_stall          (core_stall),
        .core_rdata          (core_rdata),
        .core_rvalid         (core_rvalid),
        .ldr_req             (ldr_req),
        .ldr_we              (ldr_we),
        .ldr_addr            (ldr_addr),
        .ldr_wdata           (ldr_wdata),
        .ldr_gnt             (ldr_gnt),
        .ldr_rdata           (ldr_rdata),
        .ldr_rvalid          (ldr_rvalid),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_we              (mem_we),
        .mem_re              (mem_re),
        .mem_rdata           (mem_rdata),
        .stat_core_stall_cnt (stat_core_stall_cnt),
        .stat_ldr_gnt_cnt    (stat_ldr_gnt_cnt)
    );

    task automatic set_core(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_req = req; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic set_ldr(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ldr_req = req; ldr_we = we; ldr_addr = a; ldr_wdata = d;
    endtask

    // Requests held high during reset must not produce any activity.
    task automatic test_reset();
        reset = 1'b1;
        set_core(1'b1, 1'b0, 64'h40, 64'h0);
        set_ldr(1'b1, 1'b1, 64'h48, 64'h1);
        @(negedge clk); #1;
        n_vec++;
        if ({core_stall, core_rvalid, ldr_gnt, ldr_rvalid, mem_we, mem_re} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 000000", {core_stall, core_rvalid, ldr_gnt, ldr_rvalid, mem_we, mem_re});
        end
        n_vec++;
        if (mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin
            n_err++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
        end
        n_vec++;
        if (core_rdata !== 64'h0 || ldr_rdata !== 64'h0) begin
            n_err++; $display("FAIL reset_rdata: got core=%h ldr=%h want 0/0", core_rdata, ldr_rdata);
        end
        n_vec++;
        if (stat_core_stall_cnt !== 32'd0 || stat_ldr_gnt_cnt !== 32'd0) begin
            n_err++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_core_stall_cnt, stat_ldr_gnt_cnt);
        end
        set_core(1'b0, 1'b0, 64'h0, 64'h0);
        set_ldr(1'b0, 1'b0, 64'h0, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        $display("test_reset done");
    endtask

    // SW 0x10=0xAA without stall, then LW 0x10 with one stall cycle.
    task automatic test_core_only();
        @(negedge clk); set_core(1'b1, 1'b1, 64'h10, 64'hAA); #1;
        n_vec++;
        if ({core_stall, mem_we, mem_re} !== 3'b010) begin
            n_err++; $display("FAIL core_sw_ctrl: got stall/we/re=%b want 010", {core_stall, mem_we, mem_re});
        end
        n_vec++;
        if (mem_addr !== 64'h10 || mem_wdata !== 64'hAA) begin
            n_err++; $display("FAIL core_sw_bus: got addr=%h wdata=%h want 10/aa", mem_addr, mem_wdata);
        end
        @(negedge clk); set_core(1'b1, 1'b0, 64'h10, 64'h0); #1;
        n_vec++;
        if ({core_stall, mem_re, mem_we, core_rvalid} !== 4'b1100) begin
            n_err++; $display("FAIL core_lw_grant: got stall/re/we/rvalid=%b want 1100", {core_stall, mem_re, mem_we, core_rvalid});
        end
        @(negedge clk); #1;
        n_vec++;
        if ({core_stall, core_rvalid, mem_re} !== 3'b010) begin
            n_err++; $display("FAIL core_lw_rsp_ctrl: got stall/rvalid/re=%b want 010", {core_stall, core_rvalid, mem_re});
        end
        n_vec++;
        if (core_rdata !== 64'hAA) begin
            n_err++; $display("FAIL core_lw_rdata: got %h want aa", core_rdata);
        end
        @(negedge clk); set_core(1'b0, 1'b0, 64'h0, 64'h0); #1;
        n_vec++;
        if ({mem_we, mem_re, core_rvalid} !== 3'b000 || mem_addr !== 64'h10) begin
            n_err++; $display("FAIL core_idle_hold: got we/re/rvalid=%b addr=%h want 000/10", {mem_we, mem_re, core_rvalid}, mem_addr);
        end
        $display("test_core_only done");
    endtask

    // Loader writes 0x0..0x18, then back-to-back reads of the same words.
    task automatic test_loader_only();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); set_ldr(1'b1, 1'b1, 64'(8 * i), 64'h1000 + 64'(i)); #1;
            n_vec++;
            if ({ldr_gnt, mem_we, mem_re} !== 3'b110 || mem_addr !== 64'(8 * i)) begin
                n_err++; $display("FAIL ldr_wr_%0d: got gnt/we/re=%b addr=%h want 110/%h", i, {ldr_gnt, mem_we, mem_re}, mem_addr, 8 * i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); set_ldr(1'b1, 1'b0, 64'(8 * i), 64'h0); #1;
            n_vec++;
            if ({ldr_gnt, mem_re, mem_we} !== 3'b110 || mem_addr !== 64'(8 * i)) begin
                n_err++; $display("FAIL ldr_rd_gnt_%0d: got gnt/re/we=%b addr=%h want 110/%h", i, {ldr_gnt, mem_re, mem_we}, mem_addr, 8 * i);
            end
            n_vec++;
            if (ldr_rvalid !== (i > 0)) begin
                n_err++; $display("FAIL ldr_rd_rvalid_%0d: got %b want %b", i, ldr_rvalid, i > 0);
            end
            if (i > 0) begin
                n_vec++;
                if (ldr_rdata !== 64'h1000 + 64'(i - 1)) begin
                    n_err++; $display("FAIL ldr_rd_data_%0d: got %h want %h", i - 1, ldr_rdata, 64'h1000 + 64'(i - 1));
                end
            end
        end
        @(negedge clk); set_ldr(1'b0, 1'b0, 64'h0, 64'h0); #1;
        n_vec++;
        if ({ldr_rvalid, ldr_gnt} !== 2'b10 || ldr_rdata !== 64'h1003) begin
            n_err++; $display("FAIL ldr_rd_last: got rvalid/gnt=%b data=%h want 10/1003", {ldr_rvalid, ldr_gnt}, ldr_rdata);
        end
        @(negedge clk); #1;
        n_vec++;
        if (ldr_rvalid !== 1'b0) begin
            n_err++; $display("FAIL ldr_rvalid_once: got %b want 0", ldr_rvalid);
        end
        $display("test_loader_only done");
    endtask

    // Continuous core writes vs loader writes: loader wins every 5th cycle.
    task automatic test_starvation();
        logic lw;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            set_core(1'b1, 1'b1, 64'h20, 64'hC0DE);
            set_ldr(1'b1, 1'b1, 64'h28, 64'h5A5A);
            #1;
            lw = ((k % 5) == 0);
            n_vec++;
            if ({ldr_gnt, core_stall} !== {lw, lw}) begin
                n_err++; $display("FAIL starve_gnt_c%0d: got gnt/stall=%b want %b%b", k, {ldr_gnt, core_stall}, lw, lw);
            end
            n_vec++;
            if (mem_we !== 1'b1 || mem_addr !== (lw ? 64'h28 : 64'h20) || mem_wdata !== (lw ? 64'h5A5A : 64'hC0DE)) begin
                n_err++; $display("FAIL starve_bus_c%0d: got we=%b addr=%h wdata=%h", k, mem_we, mem_addr, mem_wdata);
            end
        end
        @(negedge clk);
        set_core(1'b0, 1'b0, 64'h0, 64'h0);
        set_ldr(1'b0, 1'b0, 64'h0, 64'h0);
        #1;
        n_vec++;
        if ({mem_we, mem_re, ldr_gnt, core_stall} !== 4'b0000 || mem_addr !== 64'h28) begin
            n_err++; $display("FAIL starve_idle: got we/re/gnt/stall=%b addr=%h want 0000/28", {mem_we, mem_re, ldr_gnt, core_stall}, mem_addr);
        end
        $display("test_starvation done");
    endtask

    // Accumulated so far: 1 (core LW) + 4 (starvation) stall cycles,
    // 8 (loader-only) + 4 (starvation) loader grants.
    task automatic test_stats();
`ifdef DMEM_ARB_STATS_EN
        n_vec++;
        if (stat_core_stall_cnt !== 32'd5) begin
            n_err++; $display("FAIL stats_stall: got %0d want 5", stat_core_stall_cnt);
        end
        n_vec++;
        if (stat_ldr_gnt_cnt !== 32'd12) begin
            n_err++; $display("FAIL stats_gnt: got %0d want 12", stat_ldr_gnt_cnt);
        end
`else
        n_vec++;
        if (stat_core_stall_cnt !== 32'd0 || stat_ldr_gnt_cnt !== 32'd0) begin
            n_err++; $display("FAIL stats_off: got %0d/%0d want 0/0", stat_core_stall_cnt, stat_ldr_gnt_cnt);
        end
`endif
        $display("test_stats done");
    endtask

    // Loader write granted in the core response cycle, then loader read-back.
    task automatic test_core_rsp_overlap();
        @(negedge clk); set_core(1'b1, 1'b0, 64'h20, 64'h0); #1;
        n_vec++;
        if ({core_stall, mem_re} !== 2'b11) begin
            n_err++; $display("FAIL ovl_lw_grant: got stall/re=%b want 11", {core_stall, mem_re});
        end
        @(negedge clk); set_ldr(1'b1, 1'b1, 64'h30, 64'h55); #1;
        n_vec++;
        if ({core_rvalid, ldr_gnt, core_stall, mem_we, mem_re} !== 5'b11010) begin
            n_err++; $display("FAIL ovl_rsp_ctrl: got rvalid/gnt/stall/we/re=%b want 11010", {core_rvalid, ldr_gnt, core_stall, mem_we, mem_re});
        end
        n_vec++;
        if (mem_addr !== 64'h30 || core_rdata !== 64'hC0DE) begin
            n_err++; $display("FAIL ovl_rsp_data: got addr=%h rdata=%h want 30/c0de", mem_addr, core_rdata);
        end
        @(negedge clk);
        set_core(1'b0, 1'b0, 64'h0, 64'h0);
        set_ldr(1'b1, 1'b0, 64'h30, 64'h0);
        #1;
        n_vec++;
        if ({ldr_gnt, mem_re, core_rvalid} !== 3'b110) begin
            n_err++; $display("FAIL ovl_ldr_rd: got gnt/re/rvalid=%b want 110", {ldr_gnt, mem_re, core_rvalid});
        end
        @(negedge clk); set_ldr(1'b0, 1'b0, 64'h0, 64'h0); #1;
        n_vec++;
        if (ldr_rvalid !== 1'b1 || ldr_rdata !== 64'h55) begin
            n_err++; $display("FAIL ovl_ldr_data: got rvalid=%b data=%h want 1/55", ldr_rvalid, ldr_rdata);
        end
        $display("test_core_rsp_overlap done");
    endtask

    // Reset asserted while a read response is pending suppresses rvalid.
    task automatic test_reset_mid();
        @(negedge clk); set_core(1'b1, 1'b0, 64'h30, 64'h0); #1;
        n_vec++;
        if (core_stall !== 1'b1) begin
            n_err++; $display("FAIL rstmid_core_grant: got stall=%b want 1", core_stall);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        set_core(1'b0, 1'b0, 64'h0, 64'h0);
        @(negedge clk); #1;
        n_vec++;
        if ({core_rvalid, core_stall, mem_we, mem_re} !== 4'b0 || core_rdata !== 64'h0 || mem_addr !== 64'h0) begin
            n_err++; $display("FAIL rstmid_core: got rvalid/stall/we/re=%b rdata=%h addr=%h want 0000/0/0", {core_rvalid, core_stall, mem_we, mem_re}, core_rdata, mem_addr);
        end
        reset = 1'b0;
        @(negedge clk); #1;
        n_vec++;
        if (core_rvalid !== 1'b0) begin
            n_err++; $display("FAIL rstmid_core_after: got rvalid=%b want 0", core_rvalid);
        end
        @(negedge clk); set_ldr(1'b1, 1'b0, 64'h30, 64'h0); #1;
        n_vec++;
        if (ldr_gnt !== 1'b1) begin
            n_err++; $display("FAIL rstmid_ldr_grant: got gnt=%b want 1", ldr_gnt);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        set_ldr(1'b0, 1'b0, 64'h0, 64'h0);
        @(negedge clk); #1;
        n_vec++;
        if ({ldr_rvalid, ldr_gnt} !== 2'b00 || ldr_rdata !== 64'h0) begin
            n_err++; $display("FAIL rstmid_ldr: got rvalid/gnt=%b rdata=%h want 00/0", {ldr_rvalid, ldr_gnt}, ldr_rdata);
        end
        n_vec++;
        if (stat_core_stall_cnt !== 32'd0 || stat_ldr_gnt_cnt !== 32'd0) begin
            n_err++; $display("FAIL rstmid_stats: got %0d/%0d want 0/0", stat_core_stall_cnt, stat_ldr_gnt_cnt);
        end
        reset = 1'b0;
        @(negedge clk); #1;
        n_vec++;
        if (ldr_rvalid !== 1'b0) begin
            n_err++; $display("FAIL rstmid_ldr_after: got rvalid=%b want 0", ldr_rvalid);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tb_mem[i] = '0;
        reset = 1'b1;
        set_core(1'b0, 1'b0, 64'h0, 64'h0);
        set_ldr(1'b0, 1'b0, 64'h0, 64'h0);
        test_reset();
        test_core_only();
        test_loader_only();
        test_starvation();
        test_stats();
        test_core_rsp_overlap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates the single-ported data memory between the pipeline MEM stage (core port) and an external loader/debug port used to preload or inspect memory. It sits between the EX/MEM register outputs and the data memory. It stalls the core when the core loses arbitration or is waiting for read data. A bounded-starvation counter guarantees loader progress.

## Interface
Parameters:
- ADDR_W, 64, address width of both ports and memory
- DATA_W, 64, data width
- STARVE_MAX, 4, consecutive denied loader-request cycles before the loader wins the next conflict (1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- core_req  in  1  MEM stage access request (MemRead|MemWrite); held until stall drops
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  byte address
- core_wdata  in  DATA_W  store data
- core_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB takes a bubble
- core_rdata  out  DATA_W  load data, valid when core_rvalid
- core_rvalid  out  1  one-cycle load-data strobe
- ldr_req  in  1  loader request; held with payload until ldr_gnt
- ldr_we, ldr_addr, ldr_wdata  in  1/ADDR_W/DATA_W  as for core
- ldr_gnt  out  1  loader access accepted this cycle
- ldr_rdata  out  DATA_W  loader read data, valid when ldr_rvalid
- ldr_rvalid  out  1  one-cycle strobe
- mem_addr, mem_wdata  out  ADDR_W/DATA_W  to data memory
- mem_we, mem_re  out  1  memory write/read enables; never both high
- mem_rdata  in  DATA_W  combinational read data from memory
- stat_core_stall_cnt, stat_ldr_gnt_cnt  out  32  statistics (see Configuration)

## Operation
- FSM states: IDLE, CORE_RSP, LDR_RSP. Reset state IDLE.
- Winner selection (IDLE or LDR_RSP): core wins when only core requests, or when both request and starve_cnt < STARVE_MAX. Loader wins when only loader requests, or when both request and starve_cnt == STARVE_MAX.
- In CORE_RSP the core is not re-granted. The loader may be granted in that cycle.
- Grant cycle: mem_* are driven combinationally from the winner. The loser's stall/gnt stays low-progress. mem_rdata is captured into the winner's rdata register at the edge.
- Core write: core_stall=0 in its grant cycle; the access completes. Core read: core_stall=1 in grant cycle, FSM→CORE_RSP. In CORE_RSP: core_rvalid=1, core_stall=0, FSM→IDLE (or LDR_RSP if a loader read is granted there).
- Loader: ldr_gnt=1 in grant cycle (write or read). A read moves the FSM to LDR_RSP with ldr_rvalid=1 next cycle. Back-to-back loader reads are allowed.
- core_stall = core_req & ~(core granted write | state==CORE_RSP).
- starve_cnt: +1 (saturating at STARVE_MAX) each cycle ldr_req=1 and ldr_gnt=0. Cleared on ldr_gnt.
- With no request: mem_we=mem_re=0, and mem_addr/mem_wdata hold the last value.
- Reset outputs: core_stall=0, core_rvalid=0, ldr_gnt=0, ldr_rvalid=0, rdata regs=0, mem_we=mem_re=0, mem_addr/mem_wdata=0, starve_cnt=0, stat counters=0.

## Timing
- Core write: 0 added cycles uncontended. Core read: 1 stall cycle, data in next cycle.
- Loader read: data exactly 1 cycle after ldr_gnt.
- Worst-case loader wait under continuous core traffic: STARVE_MAX+1 cycles.
- Worst-case core wait: 1 loader access + its own access.
- Same-address core/loader conflict: resolved purely by grant order. A write granted in cycle N is visible to any read granted in cycle N+1 or later.
- Reset asserted mid-read: the FSM returns to IDLE and the pending rvalid is never issued. Requesters re-issue after reset.
- ldr_req dropped before grant: legal; starve_cnt clears the next cycle.

## Configuration
- DMEM_ARB_STATS_EN defined: stat_core_stall_cnt counts cycles with core_stall=1, and stat_ldr_gnt_cnt counts ldr_gnt pulses. Both are 32-bit and saturating.
- Not defined: both stat outputs are tied to 0 and no counter logic is built. The port list is unchanged.

## Structure
- Package dmem_arb_pkg: state enum (IDLE, CORE_RSP, LDR_RSP) and default width/STARVE_MAX constants.
- One sub-module, arb_starve_ctr: a saturating counter with inc/clr inputs and an at_max output.

## Test plan
- Core-only stream (SW 0x10=0xAA, LW 0x10) → SW no stall; LW core_stall=1 one cycle, then core_rvalid=1, core_rdata=0xAA.
- Loader-only writes to 0x0..0x18 then reads → ldr_gnt each cycle; each ldr_rvalid one cycle after its read grant with the written data.
- Continuous core_req plus ldr_req (STARVE_MAX=4) → loader granted on the 5th contended cycle; core_stall=1 in that cycle; starve_cnt back to 0.
- Core LW granted; loader write in CORE_RSP cycle → core_rvalid and ldr_gnt in the same cycle; mem_we=1 with the loader address.
- Reset pulsed in CORE_RSP/LDR_RSP → no rvalid after reset; all outputs at reset values.
- With DMEM_ARB_STATS_EN, scenario 3 for 20 cycles → counters match stall cycles and loader grants. Without the macro, both counters read 0.
